l1d_mem_responder: RTL and testbench
====================================

L1D_MEM_RESPONDER -- requirements
Module: l1d_mem_responder

Interface
REQ-001 SHALL have parameter LINE_AW, default 8, the backing-memory line address width.
REQ-002 SHALL have parameter BEATS, default 4, the beats per cache line, a power of 2; OFF_W = log2(BEATS).
REQ-003 SHALL have parameter DATA_W, default 64, the beat data width.
REQ-004 SHALL have parameter ID_W, default 4, the MSHR/evict id width.
REQ-005 SHALL have parameter RSP_DELAY, default 3, the pre-burst wait in cycles (>=1); it is used only under the macro in REQ-031.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clk, input, 1 bit: the sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port lf_req_vld, input, 1 bit: linefill request valid.
REQ-010 SHALL have port lf_req_rdy, output, 1 bit: linefill request ready.
REQ-011 SHALL have port lf_req_pld, input, LINE_AW + way + index + ID_W bits: {line, way, index, id}; the way and index widths come from l1d_package.
REQ-012 SHALL have port downstream_rsp_vld, output, 1 bit: linefill beat valid.
REQ-013 SHALL have port downstream_rsp_rdy, input, 1 bit: linefill beat ready.
REQ-014 SHALL have port downstream_rsp_pld, output, pack_l1d_data_pipe_downstream_rsp: {way, index, offset, wr_data, wr_last}.
REQ-015 SHALL have port downstream_rsp_id, output, ID_W bits: the MSHR id of the current burst.
REQ-016 SHALL have port evict_vld, input, 1 bit: evict beat valid; there is no ready, so every beat is accepted.
REQ-017 SHALL have port evict_pld, input, LINE_AW + OFF_W + DATA_W + 1 + ID_W bits: {line, offset, wr_data, rd_last, id}.
REQ-018 SHALL have port evict_done_en, output, 1 bit: evict-complete pulse.
REQ-019 SHALL have port evict_done_id, output, ID_W bits: the id of the completed evict.
REQ-020 SHALL have port evict_err, output, 1 bit: sticky evict protocol error.

Function
REQ-021 SHALL contain a single-port memory of BEATS*2^LINE_AW x DATA_W, addressed {line, offset}, with 1-cycle read latency and no reset of contents.
REQ-022 SHALL write the memory at {evict line, offset} with wr_data in every cycle evict_vld=1; an evict write always owns the memory port.
REQ-023 SHALL implement the linefill FSM states IDLE, WAIT (present only under the macro), RD and RSP; lf_req_rdy=1 only in IDLE; on handshake, the block captures the request and clears beat counter k to 0.
REQ-024 SHALL perform these transitions: IDLE->RD (or IDLE->WAIT under the macro); RD issues a read of {line, k} and moves to RSP next cycle, unless evict_vld=1 that cycle, in which case it stays in RD with no read issued.
REQ-025 SHALL in RSP drive downstream_rsp_vld=1 with offset=k, wr_data=read data, wr_last=(k==BEATS-1), and way/index/id as captured; the payload is held stable while rdy=0.
REQ-026 SHALL on an RSP handshake return to IDLE if wr_last=1, else increment k and move to RD; beats are ascending 0..BEATS-1 and each beat takes at least 2 cycles.
REQ-027 SHALL give a linefill handshake at cycle T, with no evict and no macro, its first beat valid at T+2 and its last beat handshake no earlier than T+2*BEATS.
REQ-028 SHALL make a read issued in a cycle after an evict write return the new data; an evict to beats already read in the current burst is not reflected in that burst.
REQ-029 SHALL keep an evict beat counter ec (OFF_W bits): it increments per evict beat and clears to 0 on rd_last; evict_err is set when evict_vld=1 and (offset!=ec, or rd_last=1 with ec!=BEATS-1, or rd_last=0 with ec==BEATS-1); evict_err stays set until reset.
REQ-030 SHALL pulse evict_done_en=1 for one cycle, the cycle after an rd_last beat, with evict_done_id = that beat's id, regardless of evict_err.

Configuration
REQ-031 SHALL, with macro L1D_MEM_RSP_DELAY_EN defined, use IDLE->WAIT and a down-counter loaded with RSP_DELAY; it moves WAIT->RD when the counter reaches 1, so the first beat is valid at T+RSP_DELAY+2. With the macro undefined, WAIT and the counter are absent and RSP_DELAY is ignored.

Reset
REQ-032 SHALL on rst drive FSM=IDLE, k=0, ec=0, delay counter=0, lf_req_rdy=1 (from the first clock after release), downstream_rsp_vld=0, evict_done_en=0, evict_done_id=0, evict_err=0, and downstream_rsp_pld/id=0.
REQ-033 SHALL on rst mid-burst drop the burst with no further beats, and drop a pending evict_done pulse; memory contents are kept.

Verification
REQ-034 SHALL cover: evict line 0x12, beats 0..3 with data 0xA0..0xA3, id 5 -> evict_done_en one cycle after beat 3, evict_done_id=5, evict_err=0.
REQ-035 SHALL cover: linefill line 0x12, way 1, id 3, rdy held 1 -> beats offset 0..3 with data 0xA0..0xA3, wr_last only on beat 3, id 3, first beat at T+2.
REQ-036 SHALL cover: a linefill with rdy=0 for 5 cycles on beat 1 -> payload stable, no beat skipped or repeated.
REQ-037 SHALL cover: evict beats to line 0x40 during RD of a linefill to line 0x12 -> the read stalls each evict cycle and the line 0x12 data is still correct.
REQ-038 SHALL cover: evict with rd_last on beat 2 -> evict_err=1 and held until rst; evict_done_en still pulses.
REQ-039 SHALL cover: rst asserted during beat 2 of a burst -> downstream_rsp_vld=0 at once, lf_req_rdy=1 after release; with L1D_MEM_RSP_DELAY_EN and RSP_DELAY=3, the first beat is at T+5.

Source files
------------

// File: rtl/l1d_package.sv
// Shared L1D cache geometry used by the data pipe and the memory responder.
package l1d_package;
  localparam int L1D_WAY_W   = 2;
  localparam int L1D_INDEX_W = 6;
endpackage

// File: rtl/l1d_mem_responder.sv
// Backing-memory model for the L1D: serves linefill bursts beat by beat and absorbs evict bursts.
// Optional pre-burst wait enabled by defining L1D_MEM_RSP_DELAY_EN (length RSP_DELAY cycles).
//
// state | meaning
// IDLE  | ready for a linefill request
// WAIT  | pre-burst delay countdown (L1D_MEM_RSP_DELAY_EN only)
// RD    | issue memory read of {line, k}; stalls while an evict owns the port
// RSP   | present beat k downstream until accepted
module l1d_mem_responder
  import l1d_package::*;
#(
  parameter int LINE_AW   = 8,
  parameter int BEATS     = 4,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int RSP_DELAY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic lf_req_vld,
  output logic lf_req_rdy,
  input  logic [LINE_AW+L1D_WAY_W+L1D_INDEX_W+ID_W-1:0] lf_req_pld,
  output logic downstream_rsp_vld,
  input  logic downstream_rsp_rdy,
  // {way, index, offset, wr_data, wr_last}
  output logic [L1D_WAY_W+L1D_INDEX_W+$clog2(BEATS)+DATA_W:0] downstream_rsp_pld,
  output logic [ID_W-1:0] downstream_rsp_id,
  input  logic evict_vld,
  input  logic [LINE_AW+$clog2(BEATS)+DATA_W+1+ID_W-1:0] evict_pld,
  output logic evict_done_en,
  output logic [ID_W-1:0] evict_done_id,
  output logic evict_err
);
  localparam int OFF_W = $clog2(BEATS);

  if (RSP_DELAY < 1 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_param
    $error("l1d_mem_responder: BEATS must be a power of 2 >= 2 and RSP_DELAY >= 1");
  end

`ifdef L1D_MEM_RSP_DELAY_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD, S_RSP} state_t;
  localparam int DLY_W = $clog2(RSP_DELAY + 1);
  logic [DLY_W-1:0] dly_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD, S_RSP} state_t;
`endif

  state_t state;
  logic [OFF_W-1:0] k;
  logic [LINE_AW-1:0] line_q;
  logic [L1D_WAY_W-1:0] way_q;
  logic [L1D_INDEX_W-1:0] idx_q;
  logic [ID_W-1:0] id_q;
  logic [DATA_W-1:0] rd_q;
  logic k_last;

  logic [LINE_AW-1:0] ev_line;
  logic [OFF_W-1:0] ev_off;
  logic [DATA_W-1:0] ev_data;
  logic ev_last;
  logic [ID_W-1:0] ev_id;
  logic [OFF_W-1:0] ec;
  logic ec_last;
  logic rd_en;

  logic [DATA_W-1:0] mem [BEATS*(2**LINE_AW)];

  assign {ev_line, ev_off, ev_data, ev_last, ev_id} = evict_pld;
  assign k_last  = (k == OFF_W'(BEATS - 1));
  assign ec_last = (ec == OFF_W'(BEATS - 1));
  assign rd_en   = (state == S_RD) && !evict_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      line_q <= '0;
      way_q  <= '0;
      idx_q  <= '0;
      id_q   <= '0;
`ifdef L1D_MEM_RSP_DELAY_EN
      dly_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (lf_req_vld) begin
            {line_q, way_q, idx_q, id_q} <= lf_req_pld;
            k <= '0;
`ifdef L1D_MEM_RSP_DELAY_EN
            dly_cnt <= DLY_W'(RSP_DELAY);
            state   <= S_WAIT;
`else
            state <= S_RD;
`endif
          end
        end
`ifdef L1D_MEM_RSP_DELAY_EN
        S_WAIT: begin
          dly_cnt <= dly_cnt - 1'b1;
          if (dly_cnt == DLY_W'(1)) state <= S_RD;
        end
`endif
        S_RD: begin
          if (!evict_vld) state <= S_RSP;
        end
        S_RSP: begin
          if (downstream_rsp_rdy) begin
            if (k_last) begin
              state <= S_IDLE;
            end else begin
              k     <= k + 1'b1;
              state <= S_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single port: an evict write wins; the read register only moves on an issued read, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (evict_vld) mem[{ev_line, ev_off}] <= ev_data;
    else if (rd_en) rd_q <= mem[{line_q, k}];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ec            <= '0;
      evict_err     <= 1'b0;
      evict_done_en <= 1'b0;
      evict_done_id <= '0;
    end else begin
      evict_done_en <= evict_vld && ev_last;
      if (evict_vld) begin
        ec <= ev_last ? '0 : ec + 1'b1;
        if (ev_off != ec || ev_last != ec_last) evict_err <= 1'b1;
        if (ev_last) evict_done_id <= ev_id;
      end
    end
  end

  assign lf_req_rdy         = (state == S_IDLE);
  assign downstream_rsp_vld = (state == S_RSP);
  assign downstream_rsp_pld = downstream_rsp_vld ? {way_q, idx_q, k, rd_q, k_last} : '0;
  assign downstream_rsp_id  = downstream_rsp_vld ? id_q : '0;

endmodule

// File: tb/tb_l1d_mem_responder.sv
// Directed bench for l1d_mem_responder: evict bursts, linefill timing, backpressure, evict stalls, errors, reset.
module tb_l1d_mem_responder;
  import l1d_package::*;

  localparam int LINE_AW   = 8;
  localparam int BEATS     = 4;
  localparam int DATA_W    = 64;
  localparam int ID_W      = 4;
  localparam int RSP_DELAY = 3;
  localparam int OFF_W     = 2;
  localparam int RSP_W     = L1D_WAY_W + L1D_INDEX_W + OFF_W + DATA_W + 1;
`ifdef L1D_MEM_RSP_DELAY_EN
  localparam int FIRST_LAT = RSP_DELAY + 2;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lf_req_vld = 1'b0;
  logic lf_req_rdy;
  logic [LINE_AW+L1D_WAY_W+L1D_INDEX_W+ID_W-1:0] lf_req_pld = '0;
  logic downstream_rsp_vld;
  logic downstream_rsp_rdy = 1'b1;
  logic [RSP_W-1:0] downstream_rsp_pld;
  logic [ID_W-1:0] downstream_rsp_id;
  logic evict_vld = 1'b0;
  logic [LINE_AW+OFF_W+DATA_W+1+ID_W-1:0] evict_pld = '0;
  logic evict_done_en;
  logic [ID_W-1:0] evict_done_id;
  logic evict_err;

  int n_chk = 0;
  int n_bad = 0;

  l1d_mem_responder #(
    .LINE_AW(LINE_AW), .BEATS(BEATS), .DATA_W(DATA_W), .ID_W(ID_W), .RSP_DELAY(RSP_DELAY)
  ) dut (
    .clk(clk), .rst(rst),
    .lf_req_vld(lf_req_vld), .lf_req_rdy(lf_req_rdy), .lf_req_pld(lf_req_pld),
    .downstream_rsp_vld(downstream_rsp_vld), .downstream_rsp_rdy(downstream_rsp_rdy),
    .downstream_rsp_pld(downstream_rsp_pld), .downstream_rsp_id(downstream_rsp_id),
    .evict_vld(evict_vld), .evict_pld(evict_pld),
    .evict_done_en(evict_done_en), .evict_done_id(evict_done_id), .evict_err(evict_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RSP_W-1:0] rsp(input logic [L1D_WAY_W-1:0] way,
                                           input logic [L1D_INDEX_W-1:0] idx,
                                           input logic [OFF_W-1:0] off,
                                           input logic [DATA_W-1:0] data,
                                           input logic last);
    return {way, idx, off, data, last};
  endfunction

  task automatic lf_start(input logic [LINE_AW-1:0] line, input logic [L1D_WAY_W-1:0] way,
                          input logic [L1D_INDEX_W-1:0] idx, input logic [ID_W-1:0] id);
    chk("lf_rdy_before_req", lf_req_rdy, 1'b1);
    lf_req_vld = 1'b1;
    lf_req_pld = {line, way, idx, id};
    tick();
    lf_req_vld = 1'b0;
    lf_req_pld = '0;
  endtask

  task automatic ev_drive(input logic [LINE_AW-1:0] line, input logic [OFF_W-1:0] off,
                          input logic [DATA_W-1:0] data, input logic last, input logic [ID_W-1:0] id);
    evict_vld = 1'b1;
    evict_pld = {line, off, data, last, id};
    tick();
  endtask

  task automatic ev_idle();
    evict_vld = 1'b0;
    evict_pld = '0;
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!downstream_rsp_vld && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, downstream_rsp_vld, 1'b1);
  endtask

  // Waits for a beat, checks it, and lets it handshake (rdy assumed 1).
  task automatic exp_beat(input string tag, input logic [L1D_WAY_W-1:0] way,
                          input logic [L1D_INDEX_W-1:0] idx, input logic [OFF_W-1:0] off,
                          input logic [DATA_W-1:0] data, input logic last, input logic [ID_W-1:0] id);
    wait_vld(tag);
    chk({tag, "_pld"}, downstream_rsp_pld, rsp(way, idx, off, data, last));
    chk({tag, "_id"}, downstream_rsp_id, id);
    tick();
  endtask

  initial begin
    #1;
    chk("rst_vld", downstream_rsp_vld, 1'b0);
    chk("rst_pld", downstream_rsp_pld, '0);
    chk("rst_done_en", evict_done_en, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rst_rdy", lf_req_rdy, 1'b1);
    chk("rst_id", downstream_rsp_id, '0);
    chk("rst_done_id", evict_done_id, '0);
    chk("rst_err", evict_err, 1'b0);

    // Evict line 0x12 with A0..A3, id 5
    for (int i = 0; i < 4; i++) begin
      ev_drive(8'h12, OFF_W'(i), 64'hA0 + 64'(i), i == 3, 4'd5);
      if (i < 3) chk("ev12_done_early", evict_done_en, 1'b0);
    end
    ev_idle();
    chk("ev12_done_en", evict_done_en, 1'b1);
    chk("ev12_done_id", evict_done_id, 4'd5);
    chk("ev12_err", evict_err, 1'b0);
    tick();
    chk("ev12_done_pulse", evict_done_en, 1'b0);

    // Linefill line 0x12 with exact cycle timing
    lf_start(8'h12, 2'd1, 6'h15, 4'd3);
    chk("lf12_t1_vld", downstream_rsp_vld, 1'b0);
    repeat (FIRST_LAT - 2) begin
      tick();
      chk("lf12_wait_vld", downstream_rsp_vld, 1'b0);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        tick();
        chk("lf12_rd_gap", downstream_rsp_vld, 1'b0);
        tick();
      end
      chk("lf12_beat_vld", downstream_rsp_vld, 1'b1);
      chk("lf12_beat_pld", downstream_rsp_pld,
          rsp(2'd1, 6'h15, OFF_W'(b), 64'hA0 + 64'(b), b == 3));
      chk("lf12_beat_id", downstream_rsp_id, 4'd3);
    end
    tick();
    chk("lf12_end_rdy", lf_req_rdy, 1'b1);
    chk("lf12_end_vld", downstream_rsp_vld, 1'b0);

    // Backpressure on beat 1 of a line 0x20 linefill
    for (int i = 0; i < 4; i++) ev_drive(8'h20, OFF_W'(i), 64'hB0 + 64'(i), i == 3, 4'd7);
    ev_idle();
    chk("ev20_done_id", evict_done_id, 4'd7);
    lf_start(8'h20, 2'd2, 6'h05, 4'd9);
    exp_beat("bp_b0", 2'd2, 6'h05, 2'd0, 64'hB0, 1'b0, 4'd9);
    downstream_rsp_rdy = 1'b0;
    wait_vld("bp_b1");
    chk("bp_b1_pld", downstream_rsp_pld, rsp(2'd2, 6'h05, 2'd1, 64'hB1, 1'b0));
    repeat (5) begin
      tick();
      chk("bp_hold_vld", downstream_rsp_vld, 1'b1);
      chk("bp_hold_pld", downstream_rsp_pld, rsp(2'd2, 6'h05, 2'd1, 64'hB1, 1'b0));
    end
    downstream_rsp_rdy = 1'b1;
    tick();
    exp_beat("bp_b2", 2'd2, 6'h05, 2'd2, 64'hB2, 1'b0, 4'd9);
    exp_beat("bp_b3", 2'd2, 6'h05, 2'd3, 64'hB3, 1'b1, 4'd9);
    chk("bp_end_rdy", lf_req_rdy, 1'b1);

    // Evict to line 0x40 while a linefill of line 0x12 sits in RD
    lf_start(8'h12, 2'd3, 6'h2A, 4'd4);
    for (int i = 0; i < 4; i++) begin
      ev_drive(8'h40, OFF_W'(i), 64'hC0 + 64'(i), i == 3, 4'd6);
      chk("stall_vld", downstream_rsp_vld, 1'b0);
    end
    ev_idle();
    chk("ev40_done_en", evict_done_en, 1'b1);
    chk("ev40_done_id", evict_done_id, 4'd6);
    for (int b = 0; b < 4; b++)
      exp_beat("stall_lf12", 2'd3, 6'h2A, OFF_W'(b), 64'hA0 + 64'(b), b == 3, 4'd4);
    lf_start(8'h40, 2'd0, 6'h3F, 4'd2);
    for (int b = 0; b < 4; b++)
      exp_beat("lf40", 2'd0, 6'h3F, OFF_W'(b), 64'hC0 + 64'(b), b == 3, 4'd2);

    // Early rd_last on beat 2 raises a sticky error; done still pulses
    for (int i = 0; i < 3; i++) begin
      ev_drive(8'h50, OFF_W'(i), 64'hD0 + 64'(i), i == 2, 4'hA);
      if (i == 1) chk("everr_pre", evict_err, 1'b0);
    end
    ev_idle();
    chk("everr_set", evict_err, 1'b1);
    chk("everr_done_en", evict_done_en, 1'b1);
    chk("everr_done_id", evict_done_id, 4'hA);
    tick();
    chk("everr_done_pulse", evict_done_en, 1'b0);
    repeat (3) tick();
    chk("everr_sticky", evict_err, 1'b1);

    // Reset during beat 2 of a burst
    lf_start(8'h20, 2'd2, 6'h05, 4'd9);
    exp_beat("rb_b0", 2'd2, 6'h05, 2'd0, 64'hB0, 1'b0, 4'd9);
    exp_beat("rb_b1", 2'd2, 6'h05, 2'd1, 64'hB1, 1'b0, 4'd9);
    wait_vld("rb_b2");
    chk("rb_b2_pld", downstream_rsp_pld, rsp(2'd2, 6'h05, 2'd2, 64'hB2, 1'b0));
    #2 rst = 1'b1;
    #1;
    chk("rb_vld_now", downstream_rsp_vld, 1'b0);
    chk("rb_pld_now", downstream_rsp_pld, '0);
    chk("rb_id_now", downstream_rsp_id, '0);
    chk("rb_err_clr", evict_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rb_rdy", lf_req_rdy, 1'b1);
    repeat (3) begin
      tick();
      chk("rb_no_beat", downstream_rsp_vld, 1'b0);
    end
    chk("rb_err_after", evict_err, 1'b0);

    // Memory contents survive reset
    lf_start(8'h12, 2'd1, 6'h01, 4'd8);
    for (int b = 0; b < 4; b++)
      exp_beat("post_rst_lf12", 2'd1, 6'h01, OFF_W'(b), 64'hA0 + 64'(b), b == 3, 4'd8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
